bg_pixel_shifter: RTL and testbench

Background pixel serializer sitting directly downstream of the background fetch/control pipeline. Captures each tile's palette nibble and two bitplane bytes on the pipeline's data strobes, then shifts out one 6-bit colour index per pixel strobe. Applies fine horizontal pan by discarding leading pixels, and drains the final buffered tile itself once fetching stops. Delivers exactly 320 valid pixels per line to the compositor.

---
 rtl/bg_pixel_shifter.sv | 150 +++++++++++++++
 tb/tb_bg_pixel_shifter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_pixel_shifter.sv
// Background pixel serializer: stages fetched tiles, shifts out 6-bit colour indices,
// applies fine pan skip and self-drains the last tile. Optional macro: BG_TRANSPARENT_EN.
module bg_pixel_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       lineStarting,
    input  logic [3:0] panOffset,
    input  logic       palDataIn,
    input  logic [3:0] palData,
    input  logic       tileLowDataIn,
    input  logic       tileHighDataIn,
    input  logic [7:0] tileData,
    input  logic       pixelOut,
    output logic       pixelValid,
    output logic [5:0] pixelColor,
    output logic       lineDone
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [8:0] PIXELS_PER_LINE = 9'd320;

    state_t     state, stateNext;

    logic [3:0] stPal;
    logic [7:0] stLow, stHigh;
    logic       stFull;
    logic [5:0] tilesIn, expTiles;

    logic [7:0] shift0, shift1;
    logic [3:0] actPal;
    logic [3:0] actCount;

    logic [2:0] skipLeft;
    logic [8:0] validCount;
    logic       donePend;

    logic       active, emit, load, skipping, validEmit, lastPixel;
    logic [3:0] cntAfter;
    logic [5:0] color;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        active    = (state != IDLE);
        emit      = 1'b0;
        stateNext = state;

        if (((state == RUN) && pixelOut) || (state == DRAIN))
            emit = (actCount != 4'd0);

        cntAfter  = emit ? (actCount - 4'd1) : actCount;
        // A tile finishing this cycle hands over to the staged one without a gap.
        load      = active && (cntAfter == 4'd0) && stFull;
        skipping  = (skipLeft != 3'd0);
        validEmit = emit && !skipping && (validCount != PIXELS_PER_LINE);
        lastPixel = validEmit && (validCount == PIXELS_PER_LINE - 9'd1);

        unique case (state)
            IDLE:  stateNext = IDLE;
            RUN:   if (load && (tilesIn == expTiles)) stateNext = DRAIN;
            DRAIN: if ((cntAfter == 4'd0) && !load) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        if (lastPixel)
            stateNext = IDLE;
        if (lineStarting)
            stateNext = RUN;
    end

    always_comb begin
        color = {actPal, shift1[7], shift0[7]};
`ifdef BG_TRANSPARENT_EN
        // Plane bits 00 let the backdrop through regardless of palette.
        if (!shift1[7] && !shift0[7])
            color = 6'd0;
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (reset || lineStarting) begin
            stPal      <= '0;
            stLow      <= '0;
            stHigh     <= '0;
            stFull     <= 1'b0;
            tilesIn    <= '0;
            shift0     <= '0;
            shift1     <= '0;
            actPal     <= '0;
            actCount   <= '0;
            validCount <= '0;
            donePend   <= 1'b0;
            pixelValid <= 1'b0;
            pixelColor <= '0;
            lineDone   <= 1'b0;
            expTiles   <= '0;
            skipLeft   <= '0;
            if (!reset) begin
                expTiles <= (panOffset != 4'd0) ? 6'd41 : 6'd40;
                skipLeft <= panOffset[2:0];
            end
        end else begin
            pixelValid <= validEmit;
            pixelColor <= validEmit ? color : 6'd0;
            donePend   <= lastPixel;
            lineDone   <= donePend;

            actCount <= cntAfter;
            if (emit) begin
                shift0 <= {shift0[6:0], 1'b0};
                shift1 <= {shift1[6:0], 1'b0};
                if (skipping)
                    skipLeft <= skipLeft - 3'd1;
                else if (validEmit)
                    validCount <= validCount + 9'd1;
            end

            // Load overrides the shift above when both happen in one cycle.
            if (load) begin
                shift0   <= stLow;
                shift1   <= stHigh;
                actPal   <= stPal;
                actCount <= 4'd8;
            end

            if (active) begin
                if (palDataIn)
                    stPal <= palData;
                if (tileLowDataIn)
                    stLow <= tileData;
                if (tileHighDataIn) begin
                    stHigh  <= tileData;
                    stFull  <= 1'b1;
                    tilesIn <= tilesIn + 6'd1;
                end else if (load) begin
                    stFull <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bg_pixel_shifter.sv
// Directed testbench for bg_pixel_shifter: fetch cadence of 12 cycles per tile,
// valid pixels collected at the falling edge and compared against hand-built streams.
module tb_bg_pixel_shifter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lineStarting = 1'b0;
    logic [3:0] panOffset = 4'd0;
    logic       palDataIn = 1'b0;
    logic [3:0] palData = 4'd0;
    logic       tileLowDataIn = 1'b0;
    logic       tileHighDataIn = 1'b0;
    logic [7:0] tileData = 8'd0;
    logic       pixelOut = 1'b0;
    logic       pixelValid;
    logic [5:0] pixelColor;
    logic       lineDone;

    int checks = 0;
    int errors = 0;

    int         cycleNo = 0;
    logic [5:0] pixQ[$];
    int         doneCnt = 0;
    int         doneBase = 0;
    int         lastValidCyc = -1;
    int         doneCyc = -1;

    bg_pixel_shifter dut (
        .clk(clk), .reset(reset), .lineStarting(lineStarting), .panOffset(panOffset),
        .palDataIn(palDataIn), .palData(palData), .tileLowDataIn(tileLowDataIn),
        .tileHighDataIn(tileHighDataIn), .tileData(tileData), .pixelOut(pixelOut),
        .pixelValid(pixelValid), .pixelColor(pixelColor), .lineDone(lineDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    always @(negedge clk) begin
        if (pixelValid) begin
            pixQ.push_back(pixelColor);
            lastValidCyc <= cycleNo;
        end
        if (lineDone) begin
            doneCnt <= doneCnt + 1;
            doneCyc <= cycleNo;
        end
    end

    function automatic logic [5:0] colorOf(input logic [3:0] pal, input logic p1, input logic p0);
`ifdef BG_TRANSPARENT_EN
        if (!p1 && !p0) return 6'd0;
`endif
        return {pal, p1, p0};
    endfunction

    task automatic cyc(input bit ls, input bit pd, input bit lo, input bit hi, input bit px, input bit rst);
        lineStarting   = ls;
        palDataIn      = pd;
        tileLowDataIn  = lo;
        tileHighDataIn = hi;
        pixelOut       = px;
        reset          = rst;
        @(posedge clk);
        #1;
        lineStarting   = 1'b0;
        palDataIn      = 1'b0;
        tileLowDataIn  = 1'b0;
        tileHighDataIn = 1'b0;
        pixelOut       = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic slotCycle(input int c, input logic [3:0] pal, input logic [7:0] lo, input logic [7:0] hi,
                             input bit tileEn, input bit pxEn);
        palData  = pal;
        tileData = (c == 5) ? hi : lo;
        cyc(1'b0, tileEn && c == 3, tileEn && c == 3, tileEn && c == 5, pxEn && c >= 4, 1'b0);
    endtask

    task automatic runTile(input logic [3:0] pal, input logic [7:0] lo, input logic [7:0] hi,
                           input bit tileEn, input bit pxEn);
        for (int c = 0; c < 12; c++) slotCycle(c, pal, lo, hi, tileEn, pxEn);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic startLine(input logic [3:0] pan);
        panOffset = pan;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pixQ.delete();
        doneBase = doneCnt;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pixelValid); end
        checks++; if (pixelColor !== 6'd0) begin errors++; $display("FAIL reset_color: got %h want 00", pixelColor); end
        checks++; if (lineDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", lineDone); end
        pixQ.delete();
        runTile(4'h3, 8'hF0, 8'h0F, 1'b1, 1'b1);
        runTile(4'h3, 8'hF0, 8'h0F, 1'b1, 1'b1);
        checks++; if (pixQ.size() != 0) begin errors++; $display("FAIL idle_ignore: got %0d pixels want 0", pixQ.size()); end
    endtask

    task automatic test_basic_line();
        logic [5:0] exp;
        int bad = 0;
        startLine(4'd0);
        for (int t = 0; t < 40; t++) runTile(4'h3, 8'hF0, 8'h00, 1'b1, 1'b1);
        idle(20);
        checks++; if (pixQ.size() != 320) begin errors++; $display("FAIL basic_count: got %0d want 320", pixQ.size()); end
        for (int i = 0; i < pixQ.size() && i < 320; i++) begin
            exp = ((i % 8) < 4) ? colorOf(4'h3, 1'b0, 1'b1) : colorOf(4'h3, 1'b0, 1'b0);
            if (pixQ[i] !== exp && bad == 0) begin
                bad = 1;
                $display("FAIL basic_pixel[%0d]: got %h want %h", i, pixQ[i], exp);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (doneCnt - doneBase != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", doneCnt - doneBase); end
        checks++; if (doneCyc != lastValidCyc + 1) begin errors++; $display("FAIL basic_done_timing: done cycle %0d want %0d", doneCyc, lastValidCyc + 1); end
    endtask

    task automatic test_pan_skip();
        logic [5:0] expQ[$];
        logic [7:0] lo, hi;
        int bad = 0;
        startLine(4'd3);
        for (int t = 0; t < 41; t++) begin
            lo = 8'(t * 37 + 5);
            hi = 8'(t * 91 + 3);
            runTile(4'(t), lo, hi, 1'b1, 1'b1);
            for (int i = 0; i < 8; i++) expQ.push_back(colorOf(4'(t), hi[7 - i], lo[7 - i]));
        end
        idle(20);
        // First three emitted pixels are skipped; the tail of tile 40 falls beyond 320.
        checks++; if (pixQ.size() != 320) begin errors++; $display("FAIL pan_count: got %0d want 320", pixQ.size()); end
        for (int i = 0; i < pixQ.size() && i < 320; i++) begin
            if (pixQ[i] !== expQ[i + 3] && bad == 0) begin
                bad = 1;
                $display("FAIL pan_pixel[%0d]: got %h want %h", i, pixQ[i], expQ[i + 3]);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (doneCnt - doneBase != 1) begin errors++; $display("FAIL pan_done: got %0d pulses want 1", doneCnt - doneBase); end
    endtask

    task automatic test_transparent();
        logic [5:0] exp;
        int bad = 0;
`ifdef BG_TRANSPARENT_EN
        exp = 6'h00;
`else
        exp = 6'h28;
`endif
        startLine(4'd0);
        for (int t = 0; t < 40; t++) runTile(4'hA, 8'h00, 8'h00, 1'b1, 1'b1);
        idle(20);
        checks++; if (pixQ.size() != 320) begin errors++; $display("FAIL transp_count: got %0d want 320", pixQ.size()); end
        for (int i = 0; i < pixQ.size(); i++) begin
            if (pixQ[i] !== exp && bad == 0) begin
                bad = 1;
                $display("FAIL transp_pixel[%0d]: got %h want %h", i, pixQ[i], exp);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (doneCnt - doneBase != 1) begin errors++; $display("FAIL transp_done: got %0d pulses want 1", doneCnt - doneBase); end
    endtask

    task automatic test_abort();
        logic [5:0] exp;
        int bad = 0;
        startLine(4'd0);
        for (int t = 0; t < 17; t++) runTile(4'h5, 8'hAA, 8'h55, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) slotCycle(c, 4'h5, 8'hAA, 8'h55, 1'b1, 1'b1);
        checks++; if (pixelValid !== 1'b1) begin errors++; $display("FAIL abort_running: got %b want 1", pixelValid); end
        palData  = 4'h5;
        tileData = 8'hAA;
        panOffset = 4'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", pixelValid); end
        checks++; if (pixelColor !== 6'd0) begin errors++; $display("FAIL abort_color: got %h want 00", pixelColor); end
        idle(1);
        checks++; if (doneCnt - doneBase != 0) begin errors++; $display("FAIL abort_nodone: got %0d pulses want 0", doneCnt - doneBase); end
        pixQ.delete();
        doneBase = doneCnt;
        for (int t = 0; t < 40; t++) runTile(4'h5, 8'hAA, 8'h55, 1'b1, 1'b1);
        idle(20);
        checks++; if (pixQ.size() != 320) begin errors++; $display("FAIL abort_newline_count: got %0d want 320", pixQ.size()); end
        for (int i = 0; i < pixQ.size(); i++) begin
            exp = (i % 2 == 0) ? colorOf(4'h5, 1'b0, 1'b1) : colorOf(4'h5, 1'b1, 1'b0);
            if (pixQ[i] !== exp && bad == 0) begin
                bad = 1;
                $display("FAIL abort_newline_pixel[%0d]: got %h want %h", i, pixQ[i], exp);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (doneCnt - doneBase != 1) begin errors++; $display("FAIL abort_newline_done: got %0d pulses want 1", doneCnt - doneBase); end
    endtask

    task automatic test_reset_priority();
        panOffset = 4'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (pixelValid !== 1'b0 || pixelColor !== 6'd0 || lineDone !== 1'b0) begin
            errors++; $display("FAIL rstls_outputs: got %b/%h/%b want 0/00/0", pixelValid, pixelColor, lineDone);
        end
        pixQ.delete();
        runTile(4'h3, 8'hFF, 8'hFF, 1'b1, 1'b1);
        runTile(4'h3, 8'hFF, 8'hFF, 1'b1, 1'b1);
        checks++; if (pixQ.size() != 0) begin errors++; $display("FAIL rstls_idle: got %0d pixels want 0", pixQ.size()); end
    endtask

    task automatic test_reset_drain();
        startLine(4'd0);
        for (int t = 0; t < 39; t++) runTile(4'h7, 8'hC3, 8'h3C, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) slotCycle(c, 4'h7, 8'hC3, 8'h3C, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (pixelValid !== 1'b0) begin errors++; $display("FAIL drain_rst_valid: got %b want 0", pixelValid); end
        checks++; if (pixelColor !== 6'd0) begin errors++; $display("FAIL drain_rst_color: got %h want 00", pixelColor); end
        checks++; if (lineDone !== 1'b0) begin errors++; $display("FAIL drain_rst_done: got %b want 0", lineDone); end
        idle(20);
        checks++; if (pixQ.size() != 313) begin errors++; $display("FAIL drain_rst_count: got %0d want 313", pixQ.size()); end
        checks++; if (doneCnt - doneBase != 0) begin errors++; $display("FAIL drain_rst_nodone: got %0d pulses want 0", doneCnt - doneBase); end
    endtask

    task automatic test_overrun();
        int bad = 0;
        int seenB = 0;
        startLine(4'd0);
        runTile(4'h1, 8'hFF, 8'h00, 1'b1, 1'b0);   // tile A loads straight into active
        runTile(4'h2, 8'h00, 8'hFF, 1'b1, 1'b0);   // tile B staged
        runTile(4'h3, 8'hFF, 8'hFF, 1'b1, 1'b0);   // tile C overwrites B
        runTile(4'h0, 8'h00, 8'h00, 1'b0, 1'b1);   // drain A, C loads
        for (int t = 0; t < 37; t++) runTile(4'h4, 8'h0F, 8'h00, 1'b1, 1'b1);
        idle(20);
        checks++; if (pixQ.size() != 312) begin errors++; $display("FAIL overrun_count: got %0d want 312", pixQ.size()); end
        for (int i = 0; i < 16 && i < pixQ.size(); i++) begin
            if (pixQ[i] !== ((i < 8) ? 6'h05 : 6'h0F) && bad == 0) begin
                bad = 1;
                $display("FAIL overrun_pixel[%0d]: got %h want %h", i, pixQ[i], (i < 8) ? 6'h05 : 6'h0F);
            end
        end
        checks++; if (bad != 0) errors++;
        foreach (pixQ[i]) if (pixQ[i] == 6'h0A) seenB++;
        checks++; if (seenB != 0) begin errors++; $display("FAIL overrun_lost_tile: got %0d pixels of tile B want 0", seenB); end
        checks++; if (doneCnt - doneBase != 0) begin errors++; $display("FAIL overrun_nodone: got %0d pulses want 0", doneCnt - doneBase); end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_pan_skip();
        test_transparent();
        test_abort();
        test_reset_priority();
        test_reset_drain();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
